parity_frame_ctrl: RTL and testbench

- Serial frame controller for the odd-parity checking datapath.
- Sequences one frame: a start strobe, then DATA_W data bits (MSB first), then 1 parity bit, all on a 1-bit serial line.
- Evaluates odd parity over data+parity and presents the word and error flag on a valid/ready output handshake.
- Keeps saturating frame and error counters for status readout.

---
 rtl/parity_frame_if.sv | 35 +++
 rtl/parity_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_parity_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_if.sv
// ============================================================================
// Module      : parity_frame_if
// Description : Bundle of the stimulus and result signals of the odd-parity
//               frame controller. The master drives start/sdin/out_ready;
//               the slave (the controller) drives the result and status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parity_frame_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              sdin;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              par_err;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output start, sdin, out_ready,
        input  data_out, out_valid, par_err, busy, frame_cnt, err_cnt
    );

    modport slave (
        input  start, sdin, out_ready,
        output data_out, out_valid, par_err, busy, frame_cnt, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/parity_frame_ctrl.sv
// ============================================================================
// Module      : parity_frame_ctrl
// Description : Serial frame controller. After a start strobe it shifts in
//               DATA_W data bits (MSB first) and one parity bit, checks odd
//               parity, and holds the word and error flag on a valid/ready
//               output. Saturating frame and error counters for status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_ctrl #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    parity_frame_if.slave      bus
);

    // A 1-bit counter is kept even for DATA_W=1 so the range stays legal
    localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SHIFT  = 2'd1;
    localparam logic [1:0] c_S_PARITY = 2'd2;
    localparam logic [1:0] c_S_HOLD   = 2'd3;

    localparam logic [BCNT_W-1:0] c_LAST_BIT = BCNT_W'(DATA_W - 1);
    localparam logic [BCNT_W-1:0] c_BIT_ONE  = BCNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

    logic [1:0]        r_state;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_perr;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [DATA_W-1:0] w_shift_next;
    logic              w_err;
    logic              w_accept;

    // New bit enters at the LSB so the first received bit ends up as the MSB;
    // the cast keeps the low DATA_W bits, which also covers DATA_W=1
    assign w_shift_next = DATA_W'({r_shift, bus.sdin});

    // Odd parity: an even number of ones over data plus parity is an error
    assign w_err = ~(^r_shift ^ bus.sdin);

    assign w_accept = (r_state == c_S_HOLD) && bus.out_ready;

    // Frame sequencer: IDLE -> SHIFT (DATA_W bits) -> PARITY -> HOLD -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= c_S_SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                c_S_SHIFT: begin
                    r_shift   <= w_shift_next;
                    r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        r_state <= c_S_PARITY;
                    end
                end
                c_S_PARITY: begin
                    r_state <= c_S_HOLD;
                end
                c_S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Result capture on the parity edge; valid drops when downstream accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_perr  <= 1'b0;
            r_valid <= 1'b0;
        end else if (r_state == c_S_PARITY) begin
            r_data  <= r_shift;
            r_perr  <= w_err;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating status counters, updated together with the result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (r_state == c_S_PARITY) begin
            if (r_frame_cnt != '1) begin
                r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
            end
            if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.data_out  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.par_err   = r_perr;
    assign bus.busy      = (r_state != c_S_IDLE);
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_ctrl.sv
// ============================================================================
// Module      : tb_parity_frame_ctrl
// Description : Scoreboard bench for parity_frame_ctrl. The driver pushes the
//               hand-computed result of each frame; a monitor pops and
//               compares on every rising out_valid. A second instance with
//               CNT_W=2 shares the stimulus for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_frame_ctrl;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
        int                fc;
        int                ec;
        int                kc;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic sdin;
    logic out_ready;

    int   checks;
    int   errors;
    int   cyc;
    int   m_fc;
    int   m_ec;
    logic prev_v;
    exp_t q[$];

    parity_frame_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) ifm ();
    parity_frame_if #(.DATA_W(DATA_W), .CNT_W(2))     ifs ();

    assign ifm.start     = start;
    assign ifm.sdin      = sdin;
    assign ifm.out_ready = out_ready;
    assign ifs.start     = start;
    assign ifs.sdin      = sdin;
    assign ifs.out_ready = out_ready;

    parity_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifm)
    );

    parity_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per rising out_valid
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (ifm.out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data_out",  int'(ifm.data_out),  int'(e.d));
                    chk("par_err",   int'(ifm.par_err),   int'(e.e));
                    chk("frame_cnt", int'(ifm.frame_cnt), e.fc);
                    chk("err_cnt",   int'(ifm.err_cnt),   e.ec);
                    chk("latency",   cyc - e.kc,          DATA_W + 1);
                    chk("busy_hold", int'(ifm.busy),      1);
                end
            end
            prev_v = ifm.out_valid;
        end
    end

    // Drive one frame; exp_e is the hand-computed parity error flag.
    // Returns just after the parity edge, or after the HOLD->IDLE edge.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                              input logic exp_e, input bit idle_wait,
                              output int kc);
        exp_t e;
        start = 1'b1;
        sdin  = ~p;
        @(posedge clk); #1;
        start = 1'b0;
        kc    = cyc;
        m_fc++;
        if (exp_e) m_ec++;
        e.d = d; e.e = exp_e; e.fc = m_fc; e.ec = m_ec; e.kc = kc;
        q.push_back(e);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            sdin = d[i];
            @(posedge clk); #1;
        end
        sdin = p;
        @(posedge clk); #1;
        if (idle_wait) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fc = 0;
        m_ec = 0;
    endtask

    // Directed vectors: data, parity bit, expected error
    logic [DATA_W-1:0] v_d [7] = '{4'b1011, 4'b1011, 4'b0000, 4'b0000,
                                   4'b1111, 4'b0110, 4'b1000};
    logic              v_p [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic              v_e [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int kc;
        int prev_kc;
        logic [DATA_W-1:0] hold_d;
        logic              hold_e;

        checks = 0; errors = 0; cyc = 0; prev_v = 1'b0;
        m_fc = 0; m_ec = 0;
        rst = 1'b1; start = 1'b0; sdin = 1'b0; out_ready = 1'b1;

        // Reset state, before any clock edge
        #2;
        chk("rst_data_out",  int'(ifm.data_out),  0);
        chk("rst_out_valid", int'(ifm.out_valid), 0);
        chk("rst_par_err",   int'(ifm.par_err),   0);
        chk("rst_busy",      int'(ifm.busy),      0);
        chk("rst_frame_cnt", int'(ifm.frame_cnt), 0);
        chk("rst_err_cnt",   int'(ifm.err_cnt),   0);
        #20 rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back frames with out_ready tied high: 7-cycle period
        prev_kc = 0;
        for (int i = 0; i < 7; i++) begin
            send_frame(v_d[i], v_p[i], v_e[i], 1'b1, kc);
            if (i > 0) chk("frame_period", kc - prev_kc, DATA_W + 3);
            prev_kc = kc;
        end
        chk("b2b_idle", int'(ifm.busy), 0);
        chk("b2b_frame_cnt", int'(ifm.frame_cnt), 7);

        // Backpressure: result held while start/sdin toggle
        out_ready = 1'b0;
        hold_d = 4'b0101;
        hold_e = 1'b1;                     // two ones + P=0 -> even -> error
        send_frame(hold_d, 1'b0, hold_e, 1'b0, kc);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            sdin  = ~sdin;
            @(posedge clk); #1;
            chk("bp_valid",  int'(ifm.out_valid), 1);
            chk("bp_busy",   int'(ifm.busy),      1);
            chk("bp_data",   int'(ifm.data_out),  int'(hold_d));
            chk("bp_perr",   int'(ifm.par_err),   int'(hold_e));
        end
        chk("bp_frame_cnt", int'(ifm.frame_cnt), 8);
        start = 1'b1;                      // start on the transfer edge is ignored
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("bp_release_valid", int'(ifm.out_valid), 0);
        chk("bp_release_busy",  int'(ifm.busy),      0);
        @(posedge clk); #1;
        chk("bp_no_restart",    int'(ifm.busy),      0);
        chk("bp_data_retained", int'(ifm.data_out),  int'(hold_d));

        // Asynchronous reset mid-frame after two data bits
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sdin = 1'b1; @(posedge clk); #1;
        sdin = 1'b0; @(posedge clk); #1;
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_busy",      int'(ifm.busy),      0);
        chk("mid_rst_valid",     int'(ifm.out_valid), 0);
        chk("mid_rst_data_out",  int'(ifm.data_out),  0);
        chk("mid_rst_par_err",   int'(ifm.par_err),   0);
        chk("mid_rst_frame_cnt", int'(ifm.frame_cnt), 0);
        chk("mid_rst_err_cnt",   int'(ifm.err_cnt),   0);
        model_reset();
        @(posedge clk);
        #4 rst = 1'b0;
        @(posedge clk); #1;
        send_frame(4'b1100, 1'b1, 1'b0, 1'b1, kc);   // three ones -> ok
        chk("post_rst_frame_cnt", int'(ifm.frame_cnt), 1);

        // Saturation on the CNT_W=2 instance: five error frames
        #3 rst = 1'b1;
        #1 model_reset();
        @(posedge clk);
        #4 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            send_frame(4'b0000, 1'b0, 1'b1, 1'b1, kc);
            if (i == 3) begin
                chk("sat4_frame_cnt", int'(ifs.frame_cnt), 3);
                chk("sat4_err_cnt",   int'(ifs.err_cnt),   3);
            end
        end
        chk("sat_frame_cnt", int'(ifs.frame_cnt), 3);
        chk("sat_err_cnt",   int'(ifs.err_cnt),   3);
        chk("wide_err_cnt",  int'(ifm.err_cnt),   5);

        #20;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
